// File: rtl/mpu_ldst_seq_pkg.sv
// Shared MPU types and default widths used by the load/store data sequencer
// and the address generator.
package pkg_mpu;

    localparam int WIDTH_DATA_MPU  = 32;
    localparam int WIDTH_ADDR_DMEM = 12;
    localparam int WIDTH_LEN_XFER  = 12;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CFG_ID     = 3'd1,
        CFG_STRIDE = 3'd2,
        CFG_BASE   = 3'd3,
        ST_RUN     = 3'd4,
        LD_ISSUE   = 3'd5,
        LD_DRAIN   = 3'd6,
        DONE       = 3'd7
    } mpu_ldst_fsm_t;

    typedef enum logic {
        ST = 1'b0,
        LD = 1'b1
    } mpu_ldst_mode_t;

endpackage

// File: rtl/mpu_ldst_seq_if.sv
// Host-command, store/load data and data-memory bus bundle of the sequencer.
interface mpu_ldst_seq_if #(
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_ADDR = 12
);
    logic                  I_Start_St;
    logic                  I_Start_Ld;
    logic                  I_Req_Cfg;
    logic [WIDTH_DATA-1:0] I_Data_Cfg;
    logic                  I_Req_St;
    logic [WIDTH_DATA-1:0] I_Data_St;
    logic                  O_Rdy_St;
    logic                  O_Mem_Req;
    logic                  O_Mem_We;
    logic [WIDTH_ADDR-1:0] O_Mem_Addr;
    logic [WIDTH_DATA-1:0] O_Mem_Data;
    logic                  I_Mem_Rdy;
    logic                  I_Mem_Rd_V;
    logic [WIDTH_DATA-1:0] I_Mem_Rd_Data;
    logic                  O_Req_Ld;
    logic [WIDTH_DATA-1:0] O_Data_Ld;
    logic                  O_End_Store;
    logic                  O_End_Load;
    logic                  O_Busy;
    logic                  O_Err;

    modport master (
        output I_Start_St, I_Start_Ld, I_Req_Cfg, I_Data_Cfg, I_Req_St, I_Data_St,
               I_Mem_Rdy, I_Mem_Rd_V, I_Mem_Rd_Data,
        input  O_Rdy_St, O_Mem_Req, O_Mem_We, O_Mem_Addr, O_Mem_Data,
               O_Req_Ld, O_Data_Ld, O_End_Store, O_End_Load, O_Busy, O_Err
    );

    modport slave (
        input  I_Start_St, I_Start_Ld, I_Req_Cfg, I_Data_Cfg, I_Req_St, I_Data_St,
               I_Mem_Rdy, I_Mem_Rd_V, I_Mem_Rd_Data,
        output O_Rdy_St, O_Mem_Req, O_Mem_We, O_Mem_Addr, O_Mem_Data,
               O_Req_Ld, O_Data_Ld, O_End_Store, O_End_Load, O_Busy, O_Err
    );

endinterface

// File: rtl/mpu_ldst_seq_agen.sv
// Strided address register: load a base, step by stride, wrap modulo 2^WIDTH_ADDR.
module mpu_ldst_agen #(
    parameter int WIDTH_ADDR = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [WIDTH_ADDR-1:0] base,
    input  logic [WIDTH_ADDR-1:0] stride,
    output logic [WIDTH_ADDR-1:0] addr
);

    logic [WIDTH_ADDR-1:0] addr_r;

    // Address register; negative strides arrive as two's complement and wrap silently.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r <= {WIDTH_ADDR{1'b0}};
        end else if (load) begin
            addr_r <= base;
        end else if (step) begin
            addr_r <= addr_r + stride;
        end else begin
            addr_r <= addr_r;
        end
    end

    assign addr = addr_r;

endmodule

// File: rtl/mpu_ldst_seq.sv
// Load/store data sequencer: takes ID/stride/base header words, then streams
// store beats to data memory or reads load beats back toward the host.
module mpu_ldst_seq
    import pkg_mpu::*;
#(
    parameter int WIDTH_DATA = WIDTH_DATA_MPU,
    parameter int WIDTH_ADDR = WIDTH_ADDR_DMEM,
    parameter int WIDTH_LEN  = WIDTH_LEN_XFER
) (
    input  logic          clock,
    input  logic          reset,
    mpu_ldst_seq_if.slave bus
);

    localparam logic [WIDTH_LEN:0] CNT_ONE = {{WIDTH_LEN{1'b0}}, 1'b1};

    mpu_ldst_fsm_t         state_r;
    mpu_ldst_mode_t        mode_r;
    logic [WIDTH_LEN-1:0]  len_r;
    logic [WIDTH_ADDR-1:0] stride_r;
    logic [WIDTH_LEN:0]    iss_cnt_r;
    logic [WIDTH_LEN:0]    ret_cnt_r;
    logic                  err_r;
    logic                  req_ld_r;
    logic [WIDTH_DATA-1:0] data_ld_r;

    logic                  st_acc_s;
    logic                  ld_iss_s;
    logic                  ld_ret_s;
    logic                  base_hit_s;
    logic                  iss_last_s;
    logic                  ret_last_s;
    logic [WIDTH_ADDR-1:0] addr_s;
    logic                  unused_cfg_s;

    assign st_acc_s   = (state_r == ST_RUN) && bus.I_Req_St && bus.I_Mem_Rdy;
    assign ld_iss_s   = (state_r == LD_ISSUE) && bus.I_Mem_Rdy;
    assign ld_ret_s   = ((state_r == LD_ISSUE) || (state_r == LD_DRAIN)) && bus.I_Mem_Rd_V;
    assign base_hit_s = (state_r == CFG_BASE) && bus.I_Req_Cfg;
    assign iss_last_s = (iss_cnt_r + CNT_ONE) == {1'b0, len_r};
    assign ret_last_s = (ret_cnt_r + CNT_ONE) == {1'b0, len_r};
    assign unused_cfg_s = ^bus.I_Data_Cfg;

    mpu_ldst_agen #(.WIDTH_ADDR(WIDTH_ADDR)) u_agen (
        .clock  (clock),
        .reset  (reset),
        .load   (base_hit_s),
        .step   (st_acc_s | ld_iss_s),
        .base   (bus.I_Data_Cfg[WIDTH_ADDR-1:0]),
        .stride (stride_r),
        .addr   (addr_s)
    );

    // Sequencer FSM with its header registers, counters and registered host outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            mode_r    <= ST;
            len_r     <= {WIDTH_LEN{1'b0}};
            stride_r  <= {WIDTH_ADDR{1'b0}};
            iss_cnt_r <= {(WIDTH_LEN+1){1'b0}};
            ret_cnt_r <= {(WIDTH_LEN+1){1'b0}};
            err_r     <= 1'b0;
            req_ld_r  <= 1'b0;
            data_ld_r <= {WIDTH_DATA{1'b0}};
        end else begin
            err_r    <= (state_r != IDLE) && (bus.I_Start_St || bus.I_Start_Ld);
            req_ld_r <= ld_ret_s;
            if (ld_ret_s) begin
                data_ld_r <= bus.I_Mem_Rd_Data;
            end
            if (base_hit_s) begin
                iss_cnt_r <= {(WIDTH_LEN+1){1'b0}};
                ret_cnt_r <= {(WIDTH_LEN+1){1'b0}};
            end else begin
                if (st_acc_s || ld_iss_s) begin
                    iss_cnt_r <= iss_cnt_r + CNT_ONE;
                end
                if (ld_ret_s) begin
                    ret_cnt_r <= ret_cnt_r + CNT_ONE;
                end
            end
            case (state_r)
                IDLE: begin
                    if (bus.I_Start_St) begin
                        mode_r  <= ST;
                        state_r <= CFG_ID;
                    end else if (bus.I_Start_Ld) begin
                        mode_r  <= LD;
                        state_r <= CFG_ID;
                    end
                end
                CFG_ID: begin
                    if (bus.I_Req_Cfg) begin
                        len_r   <= bus.I_Data_Cfg[WIDTH_LEN-1:0];
                        state_r <= CFG_STRIDE;
                    end
                end
                CFG_STRIDE: begin
                    if (bus.I_Req_Cfg) begin
                        stride_r <= bus.I_Data_Cfg[WIDTH_ADDR-1:0];
                        state_r  <= CFG_BASE;
                    end
                end
                CFG_BASE: begin
                    if (bus.I_Req_Cfg) begin
                        if (len_r == {WIDTH_LEN{1'b0}}) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= (mode_r == ST) ? ST_RUN : LD_ISSUE;
                        end
                    end
                end
                ST_RUN: begin
                    if (st_acc_s && iss_last_s) begin
                        state_r <= DONE;
                    end
                end
                LD_ISSUE: begin
                    // A zero-latency final return can complete the transfer on the last issue.
                    if (ld_ret_s && ret_last_s) begin
                        state_r <= DONE;
                    end else if (ld_iss_s && iss_last_s) begin
                        state_r <= LD_DRAIN;
                    end
                end
                LD_DRAIN: begin
                    if (ld_ret_s && ret_last_s) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Memory request path; the store beat goes straight through with zero latency.
    always_comb begin
        bus.O_Rdy_St   = 1'b0;
        bus.O_Mem_Req  = 1'b0;
        bus.O_Mem_We   = 1'b0;
        bus.O_Mem_Data = {WIDTH_DATA{1'b0}};
        case (state_r)
            ST_RUN: begin
                bus.O_Rdy_St   = bus.I_Mem_Rdy;
                bus.O_Mem_Req  = bus.I_Req_St;
                bus.O_Mem_We   = 1'b1;
                bus.O_Mem_Data = bus.I_Data_St;
            end
            LD_ISSUE: begin
                bus.O_Mem_Req = 1'b1;
                bus.O_Mem_We  = 1'b0;
            end
            default: begin
                bus.O_Mem_Req = 1'b0;
            end
        endcase
    end

    assign bus.O_Mem_Addr  = addr_s;
    assign bus.O_Req_Ld    = req_ld_r;
    assign bus.O_Data_Ld   = data_ld_r;
    assign bus.O_End_Store = (state_r == DONE) && (mode_r == ST);
    assign bus.O_End_Load  = (state_r == DONE) && (mode_r == LD);
    assign bus.O_Busy      = (state_r != IDLE);
    assign bus.O_Err       = err_r;

endmodule
